// File: rtl/mar_seq.sv
// Memory address register with an integrated RAM access sequencer:
// latches a bus address, sequences read/write strobes with wait states, optional post-increment.
module mar_seq #(
  parameter int ADDR_WIDTH  = 9,
  parameter int BUS_WIDTH   = 32,
  parameter int STRIDE      = 1,
  parameter int WAIT_STATES = 2,
  parameter int LIMIT       = 2**ADDR_WIDTH - 1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [BUS_WIDTH-1:0]  BusMuxOut,
  input  logic                  MARin,
  input  logic                  IncEn,
  input  logic                  Read,
  input  logic                  Write,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  MemRd,
  output logic                  MemWr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LIMIT_V  = ADDR_WIDTH'(LIMIT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_V = ADDR_WIDTH'(STRIDE);
  localparam logic [3:0]            WAIT_V   = 4'(WAIT_STATES);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  inc_flag;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  unused_bus;

  assign bus_addr   = BusMuxOut[ADDR_WIDTH-1:0];
  assign unused_bus = ^BusMuxOut[BUS_WIDTH-1:ADDR_WIDTH];
  // Range check uses the address being loaded at this same edge, if any.
  assign eff_addr   = MARin ? bus_addr : Address;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      inc_flag <= 1'b0;
      Address  <= '0;
      MemRd    <= 1'b0;
      MemWr    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Fault <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (MARin) Address <= bus_addr;
          state <= S_IDLE;
          MemRd <= 1'b0;
          MemWr <= 1'b0;
          Busy  <= 1'b0;
          if (Read && Write) begin
            Fault <= 1'b1;
          end else if (Read || Write) begin
            if (eff_addr > LIMIT_V) begin
              Fault <= 1'b1;
            end else begin
              state    <= S_ACCESS;
              MemRd    <= Read;
              MemWr    <= Write;
              Busy     <= 1'b1;
              wait_cnt <= WAIT_V;
              inc_flag <= IncEn;
            end
          end
        end
        S_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state <= S_DONE;
            MemRd <= 1'b0;
            MemWr <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            if (inc_flag) Address <= Address + STRIDE_V;
          end
        end
        default: begin
          state <= S_IDLE;
          MemRd <= 1'b0;
          MemWr <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mar_seq.sv
// Directed bench for mar_seq: vector table on a WAIT_STATES=2/LIMIT=0x0FF instance,
// hand sequences for stride wrap (STRIDE=4, WAIT_STATES=0) and asynchronous clear.
module tb_mar_seq;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] BusMuxOut = '0;
  logic        MARin = 1'b0;
  logic        IncEn = 1'b0;
  logic        Read  = 1'b0;
  logic        Write = 1'b0;

  logic [8:0]  addr_a, addr_b;
  logic        rd_a, wr_a, busy_a, done_a, fault_a;
  logic        rd_b, wr_b, busy_b, done_b, fault_b;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 Clock = ~Clock;

  mar_seq #(.ADDR_WIDTH(9), .BUS_WIDTH(32), .STRIDE(1), .WAIT_STATES(2), .LIMIT(9'h0FF)) u_a (
    .Clock(Clock), .Clear(Clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .IncEn(IncEn),
    .Read(Read), .Write(Write), .Address(addr_a), .MemRd(rd_a), .MemWr(wr_a),
    .Busy(busy_a), .Done(done_a), .Fault(fault_a)
  );

  mar_seq #(.ADDR_WIDTH(9), .BUS_WIDTH(32), .STRIDE(4), .WAIT_STATES(0), .LIMIT(511)) u_b (
    .Clock(Clock), .Clear(Clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .IncEn(IncEn),
    .Read(Read), .Write(Write), .Address(addr_b), .MemRd(rd_b), .MemWr(wr_b),
    .Busy(busy_b), .Done(done_b), .Fault(fault_b)
  );

  // flags = {MemRd, MemWr, Busy, Done, Fault}
  typedef struct {
    logic        marin;
    logic        rd;
    logic        wr;
    logic        inc;
    logic [31:0] bus;
    logic [8:0]  addr;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [8:0] a, input logic [4:0] f,
                       input logic [8:0] ea, input logic [4:0] ef);
    n_vec++;
    if (a !== ea || f !== ef || (f[1] && f[0])) begin
      n_bad++;
      $display("FAIL %s: got addr=%h rd/wr/busy/done/fault=%b, want addr=%h flags=%b",
               name, a, f, ea, ef);
    end
  endtask

  task automatic drive(input logic m, input logic r, input logic w, input logic i,
                       input logic [31:0] b);
    MARin = m; Read = r; Write = w; IncEn = i; BusMuxOut = b;
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_clear;
    Clear = 1'b1;
    #2;
    Clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //              marin rd  wr  inc  bus            addr    rd,wr,busy,done,fault
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h000, 5'b00000}); // 0 idle
    vecs.push_back('{1, 1, 0, 0, 32'hFFFF_F0A5,  9'h0A5, 5'b10100}); // 1 load+read
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A5, 5'b10100}); // 2
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A5, 5'b10100}); // 3 third strobe cycle
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A5, 5'b00010}); // 4 done
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A5, 5'b00000}); // 5 idle
    vecs.push_back('{0, 1, 0, 1, 32'h0,          9'h0A5, 5'b10100}); // 6 read with inc
    vecs.push_back('{1, 0, 1, 0, 32'h55,         9'h0A5, 5'b10100}); // 7 ignored MARin/Write
    vecs.push_back('{1, 1, 1, 1, 32'h55,         9'h0A5, 5'b10100}); // 8 ignored
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A6, 5'b00010}); // 9 done, incremented
    vecs.push_back('{0, 1, 0, 0, 32'h0,          9'h0A6, 5'b10100}); // 10 back-to-back read
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A6, 5'b10100}); // 11
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A6, 5'b10100}); // 12
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0A6, 5'b00010}); // 13 done
    vecs.push_back('{1, 1, 0, 0, 32'h100,        9'h100, 5'b00001}); // 14 out of range, loads
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h100, 5'b00000}); // 15 fault drops
    vecs.push_back('{0, 1, 0, 0, 32'h0,          9'h100, 5'b00001}); // 16 current addr too high
    vecs.push_back('{1, 1, 0, 0, 32'hFF,         9'h0FF, 5'b10100}); // 17 at LIMIT is legal
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0FF, 5'b10100}); // 18
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0FF, 5'b10100}); // 19
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h0FF, 5'b00010}); // 20 done
    vecs.push_back('{0, 1, 1, 0, 32'h0,          9'h0FF, 5'b00001}); // 21 read+write conflict
    vecs.push_back('{1, 0, 1, 0, 32'h10,         9'h010, 5'b01100}); // 22 write
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h010, 5'b01100}); // 23
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h010, 5'b01100}); // 24
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h010, 5'b00010}); // 25 done
    vecs.push_back('{0, 0, 0, 0, 32'h0,          9'h010, 5'b00000}); // 26 idle

    // reset state
    #3;
    check("reset_a", addr_a, {rd_a, wr_a, busy_a, done_a, fault_a}, 9'h000, 5'b00000);
    check("reset_b", addr_b, {rd_b, wr_b, busy_b, done_b, fault_b}, 9'h000, 5'b00000);
    Clear = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].marin, vecs[i].rd, vecs[i].wr, vecs[i].inc, vecs[i].bus);
      step();
      check($sformatf("vec%0d", i), addr_a, {rd_a, wr_a, busy_a, done_a, fault_a},
            vecs[i].addr, vecs[i].flags);
    end

    // stride-4 wrap on the zero-wait instance
    drive(0, 0, 0, 0, 32'h0);
    pulse_clear();
    drive(1, 0, 0, 0, 32'h1FE);
    step();
    check("wrap_load", addr_b, {rd_b, wr_b, busy_b, done_b, fault_b}, 9'h1FE, 5'b00000);
    drive(0, 0, 1, 1, 32'h0);
    step();
    check("wrap_strobe", addr_b, {rd_b, wr_b, busy_b, done_b, fault_b}, 9'h1FE, 5'b01100);
    drive(0, 0, 0, 0, 32'h0);
    step();
    check("wrap_done", addr_b, {rd_b, wr_b, busy_b, done_b, fault_b}, 9'h002, 5'b00010);
    step();
    check("wrap_idle", addr_b, {rd_b, wr_b, busy_b, done_b, fault_b}, 9'h002, 5'b00000);

    // asynchronous clear mid-access (MemRd=1, counter=1)
    pulse_clear();
    drive(1, 1, 0, 0, 32'h33);
    step();
    drive(0, 0, 0, 0, 32'h0);
    step();
    check("pre_clear", addr_a, {rd_a, wr_a, busy_a, done_a, fault_a}, 9'h033, 5'b10100);
    #2;
    Clear = 1'b1;
    #1;
    check("async_clear", addr_a, {rd_a, wr_a, busy_a, done_a, fault_a}, 9'h000, 5'b00000);
    Clear = 1'b0;
    step();
    check("post_clear_idle", addr_a, {rd_a, wr_a, busy_a, done_a, fault_a}, 9'h000, 5'b00000);
    step();
    check("post_clear_still", addr_a, {rd_a, wr_a, busy_a, done_a, fault_a}, 9'h000, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mar_seq.md
Name: mar_seq

Overview:
- Parametrised memory address register with an integrated access sequencer. Successor to the fixed 9-bit MAR.
- Latches an address from the internal bus and drives the RAM address lines.
- Sequences RAM read/write strobes with a configurable wait-state count.
- Optionally post-increments the address by a stride for block transfers, and flags out-of-range or conflicting requests.
- Sits between the datapath bus (BusMuxOut) and the RAM/MDR interface; strobes are consumed by the control unit.

Parameters:
- ADDR_WIDTH, 9: width of the address register and the Address port.
- BUS_WIDTH, 32: width of BusMuxOut.
- STRIDE, 1: post-increment amount. Legal range is 1..2**ADDR_WIDTH-1.
- WAIT_STATES, 2: extra cycles MemRd/MemWr are held beyond the first. Legal range is 0..15.
- LIMIT, 2**ADDR_WIDTH-1: highest legal access address. Any access above it faults.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-high reset.
- BusMuxOut  in  BUS_WIDTH  datapath bus. Only bits [ADDR_WIDTH-1:0] are used.
- MARin  in  1  load the address register from BusMuxOut.
- IncEn  in  1  request post-increment of the address when an access completes. Sampled together with Read/Write.
- Read  in  1  start a read access.
- Write  in  1  start a write access.
- Address  out  ADDR_WIDTH  registered RAM address.
- MemRd  out  1  RAM read strobe.
- MemWr  out  1  RAM write strobe.
- Busy  out  1  high while an access is in progress.
- Done  out  1  one-cycle pulse when an access completes.
- Fault  out  1  one-cycle pulse when an access is rejected.

Behaviour:
- Clock and reset: one clock (Clock). Reset is asynchronous and active-high (Clear).
- Clear asserted (asynchronous) sets:
  - Address=0, state=IDLE, wait counter=0, inc flag=0.
  - MemRd=MemWr=Busy=Done=Fault=0.
  - These values take effect immediately, including mid-access. No strobe may remain high.
- All outputs are registered. There are no combinational paths from input to output.
- States:
  - IDLE: Busy=0.
  - ACCESS: Busy=1, and MemRd or MemWr=1.
  - DONE: Busy=0, Done=1.
- Address load:
  - MARin in IDLE or DONE: Address <= BusMuxOut[ADDR_WIDTH-1:0] at the edge. Upper bus bits are ignored.
  - MARin in ACCESS is ignored. Address is stable for the whole access.
- Start condition: at an edge in IDLE or DONE, Read XOR Write is high.
  - The effective address is BusMuxOut[ADDR_WIDTH-1:0] if MARin is high at the same edge; otherwise it is the current Address.
  - Effective address > LIMIT: no access. Fault=1 for one cycle, next state IDLE, Address still loads if MARin.
  - Read and Write both high: no access. Fault=1 for one cycle, next state IDLE.
  - Otherwise the next state is ACCESS:
    - MemRd=Read or MemWr=Write.
    - Counter=WAIT_STATES.
    - Inc flag=IncEn.
- In ACCESS, at each edge:
  - Counter>0: decrement the counter; strobe holds.
  - Counter==0: next state DONE. Strobe drops, Done=1.
  - If the inc flag is set, Address <= (Address+STRIDE) mod 2**ADDR_WIDTH. Wrap-around is silent, with no fault.
  - Strobe high time is exactly WAIT_STATES+1 cycles. Done rises on the edge after the last strobe cycle.
- In DONE, at the next edge:
  - Done drops.
  - A valid start at this edge enters ACCESS directly (back-to-back access, no idle cycle).
  - Otherwise the next state is IDLE.
- Read/Write/IncEn during ACCESS are ignored. There is no queuing.
- Fault and Done are never high in the same cycle.

Test Plan:
- Reset: assert Clear mid-access (MemRd=1, counter=1) -> Address, MemRd, Busy and Done go to 0 without waiting for a clock edge; after release, state is IDLE.
- Load plus read, with WAIT_STATES=2:
  - Stimulus: BusMuxOut=32'hFFFF_F0A5, MARin=1, Read=1 in one cycle.
  - Response: Address=9'h0A5, and MemRd=1, Busy=1 for 3 cycles.
  - Then Done=1 for 1 cycle, then IDLE. Upper bus bits are ignored.
- Post-increment wrap, with STRIDE=4, WAIT_STATES=0:
  - Stimulus: Address=9'h1FE, Write=1, IncEn=1.
  - Response: MemWr high for 1 cycle. Address becomes 9'h002 in the same cycle Done=1.
- Back-to-back: a second Read issued in the DONE cycle -> MemRd reasserts on the next edge with no IDLE cycle in between.
- Faults, with LIMIT=9'h0FF:
  - Stimulus: Read to 9'h100.
  - Response: Fault=1 for 1 cycle, MemRd stays 0.
  - Read and Write together -> Fault=1 for 1 cycle, no strobe.
- Ignored inputs in ACCESS: MARin=1 with BusMuxOut=32'h55 and Write=1 during a read -> Address unchanged, MemWr stays 0, and the read completes normally.
